// File: rtl/useq_next_addr_ctl_if.sv
// Bundles the pipeline-register next-address fields and the Am2911 sequencer
// control bus. The controller uses master; the sequencer side or a bench uses slave.
interface useq_next_addr_ctl_if #(
   parameter int ADDR_W = 12
);
   logic [3:0]        opcode;
   logic [ADDR_W-1:0] branch;
   logic [7:0]        cond_in;
   logic [2:0]        cond_sel;
   logic              cond_pol;

   logic              seq_s0;
   logic              seq_s1;
   logic              seq_zero;
   logic              seq_cin;
   logic              seq_re;
   logic              seq_fe;
   logic              seq_pup;
   logic [ADDR_W-1:0] seq_din;

   logic              cnt_zero;
   logic [2:0]        stk_depth;
   logic              stk_err;
   logic              illegal;
   logic              halted;

   modport master (
      input  opcode, branch, cond_in, cond_sel, cond_pol,
      output seq_s0, seq_s1, seq_zero, seq_cin, seq_re, seq_fe, seq_pup, seq_din,
      output cnt_zero, stk_depth, stk_err, illegal, halted
   );

   modport slave (
      output opcode, branch, cond_in, cond_sel, cond_pol,
      input  seq_s0, seq_s1, seq_zero, seq_cin, seq_re, seq_fe, seq_pup, seq_din,
      input  cnt_zero, stk_depth, stk_err, illegal, halted
   );
endinterface

// File: rtl/useq_next_addr_ctl.sv
// Next-address control for a cascade of Am2911 slices: opcode decode, condition
// test, loop counter and logical stack-depth tracking against the 4-deep file.
module useq_next_addr_ctl #(
   parameter int ADDR_W = 12,
   parameter int CNT_W  = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   useq_next_addr_ctl_if.master  bus
);
   typedef enum logic {ST_INIT, ST_RUN} state_t;

   localparam logic [1:0] SRC_PC  = 2'b00;
   localparam logic [1:0] SRC_AR  = 2'b01;
   localparam logic [1:0] SRC_STK = 2'b10;
   localparam logic [1:0] SRC_D   = 2'b11;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       depth;
   logic             err;

   logic       t, cnt_nz;
   logic [1:0] src;
   logic       zero_n, cin, re_n, fe_n, pup, hold, bad, cnt_ld, cnt_dec;

   assign t      = bus.cond_in[bus.cond_sel] ^ bus.cond_pol;
   assign cnt_nz = |cnt;

   always_comb begin
      src = SRC_PC; zero_n = 1'b1; cin = 1'b1; re_n = 1'b1; fe_n = 1'b1; pup = 1'b0;
      hold = 1'b0; bad = 1'b0; cnt_ld = 1'b0; cnt_dec = 1'b0;
      if (reset) begin
         zero_n = 1'b0;
         cin    = 1'b0;
      end else if (state == ST_INIT) begin
         // Present address 0 with carry so the sequencer PC lands on 1.
         zero_n = 1'b0;
      end else begin
         case (bus.opcode)
            4'h0: zero_n = 1'b0;
            4'h1: ;
            4'h2: src = SRC_D;
            4'h3: if (t) src = SRC_D;
            4'h4: if (t) begin src = SRC_D; fe_n = 1'b0; pup = 1'b1; end
            4'h5: begin src = SRC_STK; fe_n = 1'b0; end
            4'h6: if (t) begin src = SRC_STK; fe_n = 1'b0; end
            4'h7: cnt_ld = 1'b1;
            4'h8: if (cnt_nz) begin src = SRC_D; cnt_dec = 1'b1; end
            4'h9: begin fe_n = 1'b0; pup = 1'b1; end
            4'hA: begin
               // Loop back to the pushed top while counting; pop it on exit.
               if (cnt_nz) begin src = SRC_STK; cnt_dec = 1'b1; end
               else        fe_n = 1'b0;
            end
            4'hB: if (t) begin src = SRC_D; fe_n = 1'b0; end
            4'hC: re_n = 1'b0;
            4'hD: src = SRC_AR;
            4'hE: if (!t) begin cin = 1'b0; hold = 1'b1; end
            default: bad = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_INIT;
         cnt   <= '0;
         depth <= '0;
         err   <= 1'b0;
      end else if (state == ST_INIT) begin
         state <= ST_RUN;
      end else begin
         if (cnt_ld)       cnt <= bus.branch[CNT_W-1:0];
         else if (cnt_dec) cnt <= cnt - CNT_W'(1);
         // Depth saturates; the slice itself wraps, so any excursion is sticky.
         if (!fe_n) begin
            if (pup) begin
               if (depth == 3'd4) err   <= 1'b1;
               else               depth <= depth + 3'd1;
            end else begin
               if (depth == 3'd0) err   <= 1'b1;
               else               depth <= depth - 3'd1;
            end
         end
      end
   end

   assign bus.seq_s0    = src[0];
   assign bus.seq_s1    = src[1];
   assign bus.seq_zero  = zero_n;
   assign bus.seq_cin   = cin;
   assign bus.seq_re    = re_n;
   assign bus.seq_fe    = fe_n;
   assign bus.seq_pup   = pup;
   assign bus.seq_din   = bus.branch;
   assign bus.cnt_zero  = ~cnt_nz;
   assign bus.stk_depth = depth;
   assign bus.stk_err   = err;
   assign bus.illegal   = bad;
   assign bus.halted    = hold;
endmodule

// File: tb/tb_useq_next_addr_ctl.sv
// Random and directed stimulus for useq_next_addr_ctl against an action-level
// reference model (address source, push/pop, counter and depth as integers).
module tb_useq_next_addr_ctl;
   localparam int ADDR_W = 12;
   localparam int CNT_W  = 8;

   logic clock;
   logic reset;

   useq_next_addr_ctl_if #(.ADDR_W(ADDR_W)) bus ();

   useq_next_addr_ctl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.master)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_chk = 0;
   int n_err = 0;

   // model state
   int m_cnt   = 0;
   int m_depth = 0;
   bit m_err   = 0;
   bit m_init  = 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference: decide what the microprogram does this cycle, then express it on the pins.
   // vec = {s1,s0,zero,cin,re,fe,pup,halted,illegal}
   function automatic logic [8:0] ref_decode(input bit rst, input bit init, input logic [3:0] o,
                                             input bit t, input int cnt,
                                             output bit push, output bit pop,
                                             output bit ld, output bit dec);
      int  srcsel;   // 0 PC, 1 AR, 2 STACK, 3 D
      bit  force0, hold, ldar, ill, halt;
      srcsel = 0; force0 = 0; hold = 0; ldar = 0; ill = 0; halt = 0;
      push = 0; pop = 0; ld = 0; dec = 0;
      if (rst) begin
         force0 = 1; hold = 1;
      end else if (init) begin
         force0 = 1;
      end else begin
         case (o)
            0:  force0 = 1;
            2:  srcsel = 3;
            3:  if (t) srcsel = 3;
            4:  if (t) begin srcsel = 3; push = 1; end
            5:  begin srcsel = 2; pop = 1; end
            6:  if (t) begin srcsel = 2; pop = 1; end
            7:  ld = 1;
            8:  if (cnt > 0) begin srcsel = 3; dec = 1; end
            9:  push = 1;
            10: if (cnt > 0) begin srcsel = 2; dec = 1; end else pop = 1;
            11: if (t) begin srcsel = 3; pop = 1; end
            12: ldar = 1;
            13: srcsel = 1;
            14: if (!t) begin hold = 1; halt = 1; end
            15: ill = 1;
            default: ;
         endcase
      end
      return {2'(srcsel), !force0, !hold, !ldar, !(push || pop), push, halt, ill};
   endfunction

   task automatic cyc(input logic rst, input logic [3:0] o, input logic [11:0] br,
                      input logic [7:0] ci, input logic [2:0] cs, input logic cp);
      logic [8:0] exp_vec, got_vec;
      bit push, pop, ld, dec, t;
      reset = rst; bus.opcode = o; bus.branch = br;
      bus.cond_in = ci; bus.cond_sel = cs; bus.cond_pol = cp;
      #1;
      t = ci[cs] ^ cp;
      exp_vec = ref_decode(rst, m_init, o, t, m_cnt, push, pop, ld, dec);
      got_vec = {bus.seq_s1, bus.seq_s0, bus.seq_zero, bus.seq_cin, bus.seq_re,
                 bus.seq_fe, bus.seq_pup, bus.halted, bus.illegal};
      chk($sformatf("ctl op=%0h", o), 32'(got_vec), 32'(exp_vec));
      chk("din", 32'(bus.seq_din), 32'(br));
      chk("cnt_zero", 32'(bus.cnt_zero), 32'(m_cnt == 0));
      chk("depth", 32'(bus.stk_depth), 32'(m_depth));
      chk("stk_err", 32'(bus.stk_err), 32'(m_err));
      @(posedge clock);
      if (rst) begin
         m_cnt = 0; m_depth = 0; m_err = 0; m_init = 1;
      end else if (m_init) begin
         m_init = 0;
      end else begin
         if (ld)  m_cnt = int'(br) % (1 << CNT_W);
         if (dec) m_cnt = m_cnt - 1;
         if (push) begin if (m_depth == 4) m_err = 1; else m_depth++; end
         if (pop)  begin if (m_depth == 0) m_err = 1; else m_depth--; end
      end
      #1;
   endtask

   // Issue an opcode with condition T forced to tv through a random select/polarity.
   task automatic opt(input logic [3:0] o, input logic [11:0] br, input logic tv);
      logic [7:0] ci;
      logic [2:0] cs;
      logic       cp;
      ci = 8'($urandom); cs = 3'($urandom); cp = 1'($urandom);
      ci[cs] = tv ^ cp;
      cyc(1'b0, o, br, ci, cs, cp);
   endtask

   task automatic rst_n_cycles(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 4'h1, 12'h000, 8'h00, 3'd0, 1'b0);
   endtask

   initial begin
      reset = 1'b1; bus.opcode = 4'h1; bus.branch = '0;
      bus.cond_in = '0; bus.cond_sel = '0; bus.cond_pol = 1'b0;
      @(posedge clock); #1;

      rst_n_cycles(2);
      opt(4'h1, 12'h000, 1'b0);                     // INIT: opcode ignored
      opt(4'h1, 12'h000, 1'b0);
      cyc(1'b0, 4'h4, 12'h123, 8'h04, 3'd2, 1'b0);  // CJS taken
      chk("cjs_depth", 32'(bus.stk_depth), 32'd1);
      cyc(1'b0, 4'h6, 12'h000, 8'h04, 3'd2, 1'b0);  // CRTN taken
      cyc(1'b0, 4'h4, 12'h123, 8'h04, 3'd2, 1'b1);  // CJS not taken
      chk("cjs_nt_depth", 32'(bus.stk_depth), 32'd0);

      opt(4'h7, 12'h003, 1'b0);
      for (int i = 0; i < 4; i++) opt(4'h8, 12'h2A5, 1'b0);
      chk("rpct_done", 32'(bus.cnt_zero), 32'd1);

      opt(4'h9, 12'h000, 1'b0);
      opt(4'h7, 12'h002, 1'b0);
      for (int i = 0; i < 3; i++) opt(4'hA, 12'h000, 1'b1);
      chk("rfct_depth", 32'(bus.stk_depth), 32'd0);

      for (int i = 0; i < 5; i++) opt(4'h9, 12'h000, 1'b0);
      chk("push_sat", 32'(bus.stk_depth), 32'd4);
      chk("push_err", 32'(bus.stk_err), 32'd1);
      for (int i = 0; i < 5; i++) opt(4'h5, 12'h000, 1'b0);
      chk("pop_depth", 32'(bus.stk_depth), 32'd0);
      chk("err_sticky", 32'(bus.stk_err), 32'd1);
      rst_n_cycles(1);
      chk("err_clr", 32'(bus.stk_err), 32'd0);
      opt(4'h1, 12'h000, 1'b0);                     // INIT

      for (int i = 0; i < 3; i++) opt(4'hE, 12'h000, 1'b0);
      opt(4'hE, 12'h000, 1'b1);

      opt(4'h7, 12'h005, 1'b0);
      opt(4'h8, 12'h040, 1'b0);
      opt(4'h8, 12'h040, 1'b0);
      cyc(1'b1, 4'h8, 12'h040, 8'h00, 3'd0, 1'b0);  // reset mid-loop
      chk("mid_rst_cnt", 32'(bus.cnt_zero), 32'd1);
      opt(4'h8, 12'h040, 1'b0);                     // INIT

      for (int i = 0; i < 1500; i++) begin
         logic [11:0] br;
         br = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 6)) : 12'($urandom);
         if ($urandom_range(0, 59) == 0)
            cyc(1'b1, 4'($urandom), br, 8'($urandom), 3'($urandom), 1'($urandom));
         else
            cyc(1'b0, 4'($urandom), br, 8'($urandom), 3'($urandom), 1'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/useq_next_addr_ctl.md
Name: useq_next_addr_ctl

Overview:
- Next-address control unit that drives the select/stack/register controls of a cascade of Am2911 microprogram sequencer slices (ADDR_W/4 slices).
- Decodes the next-address field of the microinstruction pipeline register, tests a selected condition, and manages a loop counter.
- Tracks logical stack depth against the 4-deep sequencer file.
- Sits between the control-store pipeline register and the sequencer slices. It is the controlling end of the sequencer's S/FE/PUP/RE/ZERO/CIN/D interface.

Parameters:
- ADDR_W, 12, microprogram address width; must be a multiple of 4.
- CNT_W, 8, loop counter width; must be ≤ ADDR_W.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  4  next-address instruction from the pipeline register.
- branch  in  ADDR_W  branch/literal field from the pipeline register.
- cond_in  in  8  condition inputs.
- cond_sel  in  3  selects the cond_in bit to test.
- cond_pol  in  1  1 = invert the selected condition.
- seq_s0, seq_s1  out  1 each  sequencer mux select: {s1,s0} 00=PC, 01=AR, 10=STACK, 11=D.
- seq_zero  out  1  active low; forces the sequencer address to 0.
- seq_cin  out  1  incrementer carry-in.
- seq_re  out  1  active low; AR load.
- seq_fe  out  1  active low; stack enable.
- seq_pup  out  1  1 = push, 0 = pop (valid only when seq_fe=0).
- seq_din  out  ADDR_W  sequencer D input; always equals branch.
- cnt_zero  out  1  loop counter == 0.
- stk_depth  out  3  logical stack depth, 0..4.
- stk_err  out  1  sticky stack overflow/underflow flag.
- illegal  out  1  current opcode is reserved (0xF).
- halted  out  1  current cycle is holding the address (WAIT not satisfied).

Behaviour:
- Condition: T = cond_in[cond_sel] ^ cond_pol.
- Default outputs in RUN: s=PC, zero=1, cin=1, re=1, fe=1, pup=0.
- States: RESET, INIT, RUN.
  - While reset=1: zero=0, cin=0, fe=1, re=1; counter=0, depth=0, stk_err=0; next state INIT.
  - INIT (one cycle): zero=0, cin=1, opcode ignored. This presents address 0 and leaves sequencer PC=1. Next state RUN.
  - RUN: decode opcode combinationally every cycle.
- Opcodes (all outputs combinational from opcode, T, counter and state):
  - 0 JZ: zero=0.
  - 1 CONT: defaults.
  - 2 JMP: s=D.
  - 3 CJP: T ? s=D : CONT.
  - 4 CJS: T ? s=D, fe=0, pup=1 : CONT.
  - 5 RTN: s=STACK, fe=0, pup=0.
  - 6 CRTN: T ? RTN : CONT.
  - 7 LDCT: counter ← branch[CNT_W-1:0]; CONT.
  - 8 RPCT: if counter≠0 then s=D and counter decrements, else CONT.
  - 9 PUSH: fe=0, pup=1; CONT.
  - A RFCT: if counter≠0 then s=STACK, fe=1 and counter decrements; else fe=0, pup=0 (pop), s=PC.
  - B CJPP: T ? s=D, fe=0, pup=0 : CONT.
  - C LDAR: re=0; CONT.
  - D JAR: s=AR.
  - E WAIT: T ? CONT : s=PC, cin=0, halted=1 (same address re-presented).
  - F: behaves as CONT; illegal=1.
- Loop counter:
  - Counts N jumps after LDCT N, then falls through.
  - Never decrements below 0.
  - Unchanged by all opcodes other than 7, 8 and A.
- Stack depth:
  - Push increments depth; pop decrements depth.
  - Push at depth 4: depth stays 4, stk_err←1 (hardware wraps and overwrites).
  - Pop at depth 0: depth stays 0, stk_err←1.
  - stk_err clears only on reset.
- The sequencer stack pointer is not reset. Depth is logical only, and the first push after reset writes the slice's next entry.
- Reset asserted mid-operation wins over any opcode: counter, depth and flags clear on that edge, and the sequence resumes INIT → RUN from address 0.

Test Plan:
- Reset for 2 cycles, then release → INIT cycle with seq_zero=0, seq_cin=1. Next cycle RUN with opcode=1 → s=00, zero=1, cin=1; stk_depth=0, cnt_zero=1.
- cond_in=0x04, cond_sel=2, cond_pol=0, opcode=4, branch=0x123 → s=11, fe=0, pup=1, seq_din=0x123, depth 0→1. Then opcode=6 with T=1 → s=10, fe=0, pup=0, depth→0. With cond_pol=1 the same CJS yields CONT and depth stays 0.
- opcode=7, branch=0x003, then opcode=8 repeatedly → exactly 3 cycles with s=11 and counter 3→2→1→0; 4th cycle CONT with cnt_zero=1.
- PUSH, then LDCT 2, then RFCT ×3 → two cycles with s=10, fe=1; third cycle fe=0, pup=0, s=00; depth ends at 0.
- 5 consecutive PUSH → stk_depth saturates at 4 and stk_err=1 after the 5th. Then 5 RTN → depth 0 and stk_err stays 1. Reset → stk_err=0.
- opcode=E with T=0 for 3 cycles → cin=0, s=00, halted=1 each cycle; T=1 → cin=1, halted=0. Reset during an RPCT loop with counter=5 → counter=0, INIT cycle follows.
